data_memory_subsystem: RTL and testbench

Memory stage slave that consumes the 24-bit load/store port of the pipelined processor: `mem_write`, `mem_read`, `data_adr`, `write_data` in, `read_data` out. It holds the on-chip data RAM and a small memory-mapped I/O window. The window contains a store-to-stream TX FIFO (drained by a valid/ready consumer), a status register and an optional cycle counter. `read_data` is combinational so the processor's MEM/WB register samples it in the same cycle as the access.

---
 rtl/data_memory_subsystem.sv | 66 ++++++
 tb/tb_data_memory_subsystem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_subsystem.sv
// data_memory_subsystem: data RAM plus MMIO window (TX FIFO, STATUS, CYCLES).
// Define CYCLE_COUNTER_EN to build the free-running CYCLES register.
module data_memory_subsystem #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [23:0] data_adr,
  input  logic [23:0] write_data,
  output logic [23:0] read_data,
  output logic [23:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [23:0]   ram [RAM_WORDS];
  logic [23:0]   fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, full, pop, push_req, push;
  logic          is_tx, is_status, is_cycles;
  logic [23:0]   status, cycles;
  assign is_tx     = data_adr == 24'h800000;
  assign is_status = data_adr == 24'h800001;
  assign is_cycles = data_adr == 24'h800002;
  assign full      = count == CW'(FIFO_DEPTH);
  assign out_valid = count != '0;
  assign out_data  = fifo[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push_req  = mem_write & is_tx;
  // a full FIFO still takes a push when the head leaves on the same edge
  assign push      = push_req & (~full | pop);
  assign status    = {13'd0, overflow, full, ~out_valid, 8'(count)};
  assign read_data = !mem_read ? '0 :
                     !data_adr[23] ? ram[data_adr[AW-1:0]] :
                     is_status ? status :
                     is_cycles ? cycles : '0;
  always_ff @(posedge clk)
    if (mem_write & ~data_adr[23]) ram[data_adr[AW-1:0]] <= write_data;
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= write_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count + CW'(push) - CW'(pop);
      overflow <= (push_req & ~push) | (overflow & ~(mem_write & is_status));
    end
`ifdef CYCLE_COUNTER_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) cycles <= '0;
    else cycles <= (mem_write & is_cycles) ? '0 : cycles + 24'd1;
`else
  assign cycles = '0;
`endif
endmodule

// File: tb/tb_data_memory_subsystem.sv
// tb_data_memory_subsystem: directed plus randomized checks against a queue/array reference model.
module tb_data_memory_subsystem;
  localparam int RW = 1024, FD = 8;
  localparam logic [23:0] TX = 24'h800000, ST = 24'h800001, CY = 24'h800002;
  logic clk = 0, rst = 0, mem_write = 0, mem_read = 0, out_ready = 0;
  logic [23:0] data_adr = '0, write_data = '0;
  logic [23:0] read_data, out_data;
  logic out_valid;
  int checks = 0, failures = 0;
  logic [23:0] ram_m [RW];
  logic [23:0] q [$];
  bit ovf_m = 0;
  logic [23:0] cyc_m = '0;
  logic [23:0] exp_cyc;
  int k;
  logic [23:0] a;

  data_memory_subsystem #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
    .data_adr(data_adr), .write_data(write_data), .read_data(read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_read(input logic [23:0] adr);
    if (!mem_read) return 24'd0;
    if (!adr[23]) return ram_m[adr[9:0]];
    if (adr == ST) return {13'd0, ovf_m, q.size() == FD, q.size() == 0, 8'(q.size())};
`ifdef CYCLE_COUNTER_EN
    if (adr == CY) return cyc_m;
`endif
    return 24'd0;
  endfunction

  task automatic chk_rd(input string tag);
    chk(tag, read_data, model_read(data_adr));
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_valid"}, 24'(out_valid), 24'(q.size() > 0));
    if (q.size() > 0) chk({tag, "_data"}, out_data, q[0]);
  endtask

  task automatic set(input bit w, input bit r, input logic [23:0] adr, input logic [23:0] d);
    mem_write = w; mem_read = r; data_adr = adr; write_data = d;
    #1;
  endtask

  // one clock edge; the model applies the architectural effect of the inputs seen before it
  task automatic cycle();
    bit pop = q.size() > 0 && out_ready;
    logic [23:0] ad = data_adr, d = write_data;
    bit w = mem_write;
    @(posedge clk);
    if (rst) begin
      if (pop) void'(q.pop_front());
      cyc_m = cyc_m + 24'd1;
      if (w && !ad[23]) ram_m[ad[9:0]] = d;
      if (w && ad == TX) begin
        if (q.size() < FD) q.push_back(d);
        else ovf_m = 1;
      end
      if (w && ad == ST) ovf_m = 0;
      if (w && ad == CY) cyc_m = '0;
    end
    #1;
  endtask

  initial begin
    #2;
    chk("rst_valid", 24'(out_valid), 24'd0);
    chk("rst_rd_idle", read_data, 24'd0);
    set(0, 1, ST, 0);
    chk("rst_status", read_data, 24'h100);
    @(negedge clk);
    rst = 1; cyc_m = '0; ovf_m = 0;
    set(0, 0, 0, 0);
    repeat (10) cycle();
    set(0, 1, CY, 0);
`ifdef CYCLE_COUNTER_EN
    exp_cyc = 24'd10;
`else
    exp_cyc = 24'd0;
`endif
    chk("cyc10", read_data, exp_cyc);
    set(1, 0, CY, 24'h5a5a5a);
    cycle();
    set(0, 0, 0, 0);
    cycle();
    set(0, 1, CY, 0);
`ifdef CYCLE_COUNTER_EN
    exp_cyc = 24'd1;
`endif
    chk("cyc_after_wr", read_data, exp_cyc);
    chk_rd("cyc_model");
    set(1, 0, 24'h000005, 24'habcdef);
    cycle();
    set(0, 1, 24'h000005, 0);
    chk("ram_rd", read_data, 24'habcdef);
    set(0, 1, 24'h000405, 0);
    chk("ram_alias", read_data, 24'habcdef);
    set(0, 0, 24'h000005, 0);
    chk("ram_noread", read_data, 24'd0);
    set(1, 1, 24'h000005, 24'h111111);
    chk("ram_rw_old", read_data, 24'habcdef);
    cycle();
    set(0, 1, 24'h000005, 0);
    chk("ram_rw_new", read_data, 24'h111111);
    set(1, 0, 24'h000007, 24'h000777);
    cycle();
    out_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      set(1, 0, TX, 24'(i));
      if (i == 1) chk("empty_pre", 24'(out_valid), 24'd0);
      cycle();
      if (i == 1) begin
        chk("empty_post_v", 24'(out_valid), 24'd1);
        chk("empty_post_d", out_data, 24'h1);
      end
    end
    set(0, 1, ST, 0);
    chk("full_status", read_data, 24'h208);
    set(0, 1, TX, 0);
    chk("tx_read_zero", read_data, 24'd0);
    set(1, 0, TX, 24'd9);
    cycle();
    set(0, 1, ST, 0);
    chk("ovf_status", read_data, 24'h608);
    set(0, 0, 0, 0);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain", out_data, 24'(i));
      chk_out("drain_m");
      cycle();
    end
    out_ready = 0;
    chk("drained_valid", 24'(out_valid), 24'd0);
    set(0, 1, ST, 0);
    chk("drained_status", read_data, 24'h500);
    set(1, 0, ST, 24'(`__LINE__));
    cycle();
    set(0, 1, ST, 0);
    chk("ovf_clear", read_data, 24'h100);
    for (int i = 0; i < 8; i++) begin
      set(1, 0, TX, 24'h10 + 24'(i));
      cycle();
    end
    out_ready = 1;
    set(1, 0, TX, 24'h55);
    cycle();
    out_ready = 0;
    set(0, 1, ST, 0);
    chk("fullpop_status", read_data, 24'h208);
    set(0, 0, 0, 0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("fullpop_last", out_data, 24'h55);
      chk_out("fullpop");
      cycle();
    end
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set(1, 0, TX, 24'hc0 + 24'(i));
      cycle();
    end
    mem_write = 0; mem_read = 1; data_adr = ST;
    #1;
    rst = 0;
    #1;
    q.delete(); ovf_m = 0;
    chk("midrst_valid", 24'(out_valid), 24'd0);
    chk("midrst_status", read_data, 24'h100);
    data_adr = 24'h000007;
    #1;
    chk("midrst_ram", read_data, 24'h000777);
    @(negedge clk);
    rst = 1; cyc_m = '0;
    for (int i = 0; i < 16; i++) begin
      set(1, 0, 24'(i), 24'($urandom));
      cycle();
    end
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 9));
      a = k < 4 ? {1'b0, 13'($urandom), 10'($urandom_range(0, 15))} :
          k < 7 ? TX : k == 7 ? ST : k == 8 ? CY : 24'h800003 + 24'($urandom_range(0, 1000));
      out_ready = 1'($urandom);
      set(1'($urandom), 1'($urandom), a, 24'($urandom));
      chk_rd("rnd_rd");
      chk_out("rnd");
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
